// File: rtl/adaptive_traffic_arbiter.sv
// Adaptive N-approach intersection controller: sensor-priority green selection with
// round-robin tie-break, min/max green, amber and all-red clearance, night flashing amber.
module adaptive_traffic_arbiter #(
    parameter int N_APP      = 4,
    parameter int SENS_W     = 2,
    parameter int TIMER_W    = 6,
    parameter int GREEN_MIN  = 8,
    parameter int GREEN_MAX  = 30,
    parameter int AMBER_T    = 4,
    parameter int ALLRED_T   = 2,
    parameter int FLASH_HALF = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_APP*SENS_W-1:0]    sensor,
    input  logic                       flash_en,
    output logic [3*N_APP-1:0]         light,
    output logic [$clog2(N_APP)-1:0]   active_idx,
    output logic [1:0]                 phase,
    output logic [TIMER_W-1:0]         phase_cnt
);
    localparam int IW = $clog2(N_APP);
    localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

    typedef enum logic [1:0] {GREEN = 2'd0, AMBER = 2'd1, ALLRED = 2'd2, FLASH = 2'd3} phase_e;

    phase_e             ph_q, ph_d;
    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]      act_q, act_d;
    logic               blink_q, blink_d;
    logic [FW-1:0]      fl_q, fl_d;

    logic               gt_other, nz_other, green_exit;
    logic [IW-1:0]      nxt_idx;
    logic [SENS_W-1:0]  best_v, own_v;

    // Competing-demand flags and next-approach scan, all relative to the active approach.
    always_comb begin
        gt_other = 1'b0;
        nz_other = 1'b0;
        own_v    = sensor[int'(act_q)*SENS_W +: SENS_W];
        nxt_idx  = act_q;
        best_v   = '0;
        for (int k = 1; k < N_APP; k++) begin
            int idx;
            idx = int'(act_q) + k;
            if (idx >= N_APP) idx = idx - N_APP;
            if (sensor[idx*SENS_W +: SENS_W] > own_v) gt_other = 1'b1;
            if (sensor[idx*SENS_W +: SENS_W] != '0)   nz_other = 1'b1;
            // Strict > keeps the earliest approach in round-robin order on ties.
            if (sensor[idx*SENS_W +: SENS_W] > best_v) begin
                best_v  = sensor[idx*SENS_W +: SENS_W];
                nxt_idx = IW'(idx);
            end
        end
        green_exit = flash_en
                   | ((cnt_q >= TIMER_W'(GREEN_MIN - 1)) & gt_other)
                   | ((cnt_q == TIMER_W'(GREEN_MAX - 1)) & nz_other);
    end

    always_comb begin
        ph_d    = ph_q;
        cnt_d   = cnt_q + 1'b1;
        act_d   = act_q;
        blink_d = blink_q;
        fl_d    = fl_q;
        unique case (ph_q)
            GREEN: begin
                if (green_exit) begin
                    ph_d  = AMBER;
                    cnt_d = '0;
                end else if (cnt_q == TIMER_W'(GREEN_MAX - 1)) begin
                    cnt_d = cnt_q;
                end
            end
            AMBER: begin
                if (cnt_q == TIMER_W'(AMBER_T - 1)) begin
                    ph_d  = ALLRED;
                    cnt_d = '0;
                end
            end
            ALLRED: begin
                if (cnt_q == TIMER_W'(ALLRED_T - 1)) begin
                    cnt_d = '0;
                    if (flash_en) begin
                        ph_d    = FLASH;
                        blink_d = 1'b1;
                        fl_d    = '0;
                    end else begin
                        ph_d  = GREEN;
                        act_d = nxt_idx;
                    end
                end
            end
            FLASH: begin
                if (!flash_en) begin
                    ph_d  = ALLRED;
                    cnt_d = '0;
                end else if (fl_q == FW'(FLASH_HALF - 1)) begin
                    fl_d    = '0;
                    blink_d = ~blink_q;
                end else begin
                    fl_d = fl_q + 1'b1;
                end
            end
            default: ph_d = ALLRED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q    <= ALLRED;
            cnt_q   <= '0;
            act_q   <= IW'(N_APP - 1);
            blink_q <= 1'b0;
            fl_q    <= '0;
        end else begin
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            blink_q <= blink_d;
            fl_q    <= fl_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_APP; i++) begin
            light[3*i +: 3] = 3'b100;
            unique case (ph_q)
                GREEN:   if (IW'(i) == act_q) light[3*i +: 3] = 3'b001;
                AMBER:   if (IW'(i) == act_q) light[3*i +: 3] = 3'b010;
                FLASH:   light[3*i +: 3] = blink_q ? 3'b010 : 3'b000;
                default: light[3*i +: 3] = 3'b100;
            endcase
        end
    end

    assign active_idx = act_q;
    assign phase      = ph_q;
    assign phase_cnt  = cnt_q;
endmodule
